russian_peasant_unsigned_divider: RTL and testbench

//  Sequential unsigned divider; the inverse of the Russian-peasant unsigned multiplier.

---
 rtl/russian_peasant_div_pkg.sv | 19 +
 rtl/russian_peasant_div_step.sv | 24 ++
 rtl/russian_peasant_unsigned_divider.sv | 104 ++++++++++
 tb/tb_russian_peasant_unsigned_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/russian_peasant_div_pkg.sv
// Shared types and sizing for the Russian-peasant unsigned divider.
// Default operand width and the counter width needed to count 2W steps.
package russian_peasant_div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_W);

endpackage

// File: rtl/russian_peasant_div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and
// trial-subtracts the divisor from the widened partial remainder.
module russian_peasant_div_step
    import russian_peasant_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem,
    input  logic         a_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] next_rem,
    output logic         q_bit
);

    logic [W:0] pr;

    // pr < 2*divisor whenever rem < divisor, so the difference always fits in W bits
    always_comb begin
        pr       = {rem, a_msb};
        q_bit    = (pr >= {1'b0, divisor});
        next_rem = q_bit ? W'(pr - {1'b0, divisor}) : pr[W-1:0];
    end

endmodule

// File: rtl/russian_peasant_unsigned_divider.sv
// Sequential 2W/W unsigned divider, one quotient bit per cycle, with
// valid/ready handshakes on operand and result sides.
module russian_peasant_unsigned_divider
    import russian_peasant_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = cnt_width(W);

    state_t         state;
    logic [2*W-1:0] a_reg;
    logic [2*W-1:0] q_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   rem_reg;
    logic [CW-1:0]  cnt;
    logic           zero_div;

    logic [W-1:0]   next_rem;
    logic           q_bit;

    russian_peasant_div_step #(.W(W)) u_step (
        .rem      (rem_reg),
        .a_msb    (a_reg[2*W-1]),
        .divisor  (b_reg),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    // Held low for the whole reset interval, even though state already reads IDLE
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            b_reg       <= '0;
            rem_reg     <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= dividend;
                        b_reg       <= divisor;
                        rem_reg     <= '0;
                        q_reg       <= '0;
                        cnt         <= CW'(2 * W);
                        zero_div    <= (divisor == '0);
                        div_by_zero <= 1'b0;
                        state       <= (divisor == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    a_reg   <= {a_reg[2*W-2:0], 1'b0};
                    rem_reg <= next_rem;
                    q_reg   <= {q_reg[2*W-2:0], q_bit};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later ones wait for the consumer
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= q_reg;
                            remainder   <= rem_reg;
                            div_by_zero <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_russian_peasant_unsigned_divider.sv
// Scoreboard bench for the Russian-peasant unsigned divider: directed
// cases, back-pressure, mid-run reset and a random sweep.
module tb_russian_peasant_unsigned_divider;
    import russian_peasant_div_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    russian_peasant_unsigned_divider #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
        int   waited = 0;
        exp_t e;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("in_ready_before_op", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 'x;
        divisor  = 'x;
        if (b == 0) begin
            e.q = '1; e.r = '0; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = W'(a % b); e.dbz = 1'b0; e.lat = 2 * W + 1;
        end
        sb.push_back(e);
    endtask

    task automatic collect(input int hold);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check_eq("latency", lat, e.lat);
        check_eq("quotient", quotient, e.q);
        check_eq("remainder", remainder, e.r);
        check_eq("div_by_zero", div_by_zero, e.dbz);
        check_eq("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            dividend = 16'h1234;
            divisor  = 8'h05;
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_quotient", quotient, e.q);
            check_eq("hold_remainder", remainder, e.r);
            check_eq("hold_in_ready", in_ready, 0);
        end
        // in_valid high on the handshake edge must not be taken as a new operand
        in_valid  = 1'b1;
        dividend  = 16'h4321;
        divisor   = 8'h03;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = 'x;
        divisor   = 'x;
        out_ready = 1'b0;
        check_eq("release_valid", out_valid, 0);
        check_eq("release_idle", in_ready, 1);
        check_eq("release_q_hold", quotient, e.q);
    endtask

    initial begin
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_in_ready", in_ready, 1);

        drive_op(16'd11270, 8'd115); collect(0);
        drive_op(16'd1000, 8'd7);    collect(0);
        drive_op(16'd65535, 8'd1);   collect(0);
        drive_op(16'd65535, 8'd255); collect(0);
        drive_op(16'd0, 8'd9);       collect(0);
        drive_op(16'd5, 8'd0);       collect(0);
        drive_op(16'd9, 8'd3);       collect(0);
        drive_op(16'd50000, 8'd13);  collect(20);

        drive_op(16'd200, 8'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_quotient", quotient, 0);
        check_eq("abort_remainder", remainder, 0);
        check_eq("abort_dbz", div_by_zero, 0);
        check_eq("abort_in_ready", in_ready, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(16'd200, 8'd3); collect(0);

        for (int n = 0; n < 2500; n++) begin
            drive_op(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));
            collect(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
